escalonador_regras_fou: RTL and testbench
=========================================

Name: escalonador_regras_fou

Overview:
- Sequences the rule-evaluation datapath of the interval type-2 fuzzy processor.
- On a start request, latches the 6-bit active-FOU vector (3 membership functions per input, 2 inputs) and derives the 3x3 rule grid.
- Emits the index of each rule whose two antecedents are both active, in ascending order, one after another.
- Clears the inference accumulator before the first rule, strobes its enable per rule, and signals completion.

Parameters:
- N_MF, 3: membership functions per input. Rule count = N_MF*N_MF; the bench exercises only the default.
- LAT_INF, 2: cycles each rule index is held for the inference datapath, range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- EN_REGRAS  input  1  start request, sampled only in OCIOSO.
- FOU_ativo  input  6  [2:0] active MFs of input 1 (i=0..2), [5:3] active MFs of input 2 (j=0..2).
- Sequencia_regras  output  4  current rule index r = 3*i + j.
- regra_valida  output  1  high while Sequencia_regras holds an active rule.
- Reset_Inf  output  1  one-cycle clear of the inference accumulator.
- en_inf  output  1  accumulate strobe, last hold cycle of each rule.
- fim  output  1  one-cycle completion pulse.
- ocupado  output  1  high in every state except OCIOSO.
- estado  output  3  current state encoding, for test.

Behaviour:
- Reset (rst=0, asynchronous): state OCIOSO; all outputs 0; latched mask and hold counter cleared.
- Rule mask: 9-bit mascara[r] = FOU_q[i] & FOU_q[3+j], where FOU_q is FOU_ativo latched on the start cycle.
- State OCIOSO (000):
  - If EN_REGRAS=1 at a clock edge: latch FOU_ativo and go to LIMPA.
  - Otherwise stay.
- State LIMPA (001):
  - Reset_Inf=1 for exactly one cycle.
  - Next: EMITE with the lowest active r, or FIM if the mask is zero.
- State EMITE (010):
  - Sequencia_regras=r and regra_valida=1 for LAT_INF consecutive cycles.
  - en_inf=1 only on the last of those cycles.
  - After the last cycle: EMITE again with the next active r' > r (no idle cycle between rules), or FIM if none remain.
- State FIM (011): fim=1 for one cycle, then OCIOSO unconditionally.
- Latency: start edge to fim = 1 + N_ativas*LAT_INF + 1 cycles. Zero active rules gives 2 cycles.
- Outputs are registered.
- Sequencia_regras holds its last value outside EMITE; it is meaningful only while regra_valida=1.
- Boundary conditions:
  - EN_REGRAS while ocupado=1: ignored, not queued.
  - EN_REGRAS held high continuously: restarts on the cycle after returning to OCIOSO, so one OCIOSO cycle lies between runs.
  - FOU_ativo changing mid-run: no effect; the latched copy is used.
  - rst asserted mid-run: immediate OCIOSO with outputs 0. No fim is issued for the aborted run.
  - Rule 8 (last index): search terminates with no wrap-around.
  - Unused state encodings: recover to OCIOSO.
  - Hold counter width: ceil(log2(LAT_INF+1)); it reloads on each new rule.

Decomposition:
- Shared package holds:
  - state encodings OCIOSO/LIMPA/EMITE/FIM;
  - N_REGRAS=9 and the rule-index width of 4;
  - the rule-index formula constant N_MF.
- One combinational sub-module, prox_regra_ativa:
  - inputs: 9-bit mask, 4-bit start index, and an include-start flag;
  - outputs: next active index >= start (or > start) and an achou flag.
- The sub-module is used both in LIMPA and at the end of each EMITE hold.

Test Plan:
- Partial mask: FOU_ativo=6'b011_110, LAT_INF=2, EN pulse.
  - Response: Reset_Inf 1 cycle, then Sequencia_regras 3,3,4,4,6,6,7,7 with regra_valida high.
  - en_inf high on the 2nd cycle of each rule.
  - fim pulse 10 cycles after the start edge.
- Full mask: FOU_ativo=6'b111_111.
  - Response: indices 0..8 in order, 9 en_inf pulses, fim 20 cycles after start.
- Empty mask: FOU_ativo=6'b000_101, so no input-2 MF is active.
  - Response: Reset_Inf at cycle 1, fim at cycle 2.
  - regra_valida and en_inf never rise.
- Latch and busy: start with 6'b001_001 (rule 0 only), then change FOU_ativo to 6'b111_111 and pulse EN_REGRAS during EMITE.
  - Response: only rule 0 emitted, single fim, no second run.
- Reset mid-run: assert rst=0 during the third rule of the full-mask run.
  - Response: all outputs 0 asynchronously, estado=000, no fim.
  - A later EN_REGRAS restarts cleanly from rule 0.
- Back-to-back: EN_REGRAS held high with 6'b010_010 (rule 4).
  - Response: repeating LIMPA, EMITE(4)x2, FIM, OCIOSO, a 5-cycle period.

Source files
------------

// File: rtl/escalonador_regras_fou_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | escalonador_regras_fou_pkg                                               |
// | State encodings and rule-grid constants for the rule scheduler.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package escalonador_regras_fou_pkg;

   localparam int N_MF     = 3;
   localparam int N_REGRAS = N_MF * N_MF;
   localparam int W_REGRA  = 4;

   localparam logic [2:0] OCIOSO = 3'b000;
   localparam logic [2:0] LIMPA  = 3'b001;
   localparam logic [2:0] EMITE  = 3'b010;
   localparam logic [2:0] FIM    = 3'b011;

endpackage
`default_nettype wire

// File: rtl/escalonador_regras_fou_prox_regra_ativa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prox_regra_ativa                                                         |
// | Finds the lowest active rule index at (or strictly after) a start index. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prox_regra_ativa
   import escalonador_regras_fou_pkg::*;
#(
   parameter int N_R = N_REGRAS
) (
   input  logic [N_R-1:0]     mascara,
   input  logic [W_REGRA-1:0] inicio,
   input  logic               incl_inicio,
   output logic [W_REGRA-1:0] prox,
   output logic               achou
);

   // Descending scan so the last hit written is the lowest qualifying index.
   always_comb begin
      prox  = '0;
      achou = 1'b0;
      for (int k = N_R - 1; k >= 0; k--) begin
         if (mascara[k] &&
             ((W_REGRA'(k) > inicio) || (incl_inicio && (W_REGRA'(k) == inicio)))) begin
            prox  = W_REGRA'(k);
            achou = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/escalonador_regras_fou.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | escalonador_regras_fou                                                   |
// | Walks the active cells of the IT2 rule grid, one index per LAT_INF beats.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module escalonador_regras_fou #(
   parameter int N_MF    = 3,
   parameter int LAT_INF = 2
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            EN_REGRAS,
   input  logic [2*N_MF-1:0]                               FOU_ativo,
   output logic [escalonador_regras_fou_pkg::W_REGRA-1:0]  Sequencia_regras,
   output logic                                            regra_valida,
   output logic                                            Reset_Inf,
   output logic                                            en_inf,
   output logic                                            fim,
   output logic                                            ocupado,
   output logic [2:0]                                      estado
);
   import escalonador_regras_fou_pkg::*;

   localparam int                 c_N_R   = N_MF * N_MF;
   localparam int                 c_W_CNT = $clog2(LAT_INF + 1);
   localparam logic [c_W_CNT-1:0] c_LAT   = c_W_CNT'(LAT_INF);
   localparam logic [c_W_CNT-1:0] c_UM    = c_W_CNT'(1);

   logic [2:0]         r_state, w_next;
   logic [2*N_MF-1:0]  r_fou;
   logic [c_W_CNT-1:0] r_cnt, w_cnt;
   logic [W_REGRA-1:0] r_seq, w_seq, w_inicio, w_prox;
   logic [c_N_R-1:0]   w_mascara;
   logic               r_valida, r_reset_inf, r_en_inf, r_fim, r_ocupado;
   logic               w_valida, w_reset_inf, w_en_inf, w_fim;
   logic               w_incl, w_achou, w_ultimo;

   for (genvar gi = 0; gi < N_MF; gi++) begin : g_in1
      for (genvar gj = 0; gj < N_MF; gj++) begin : g_in2
         assign w_mascara[gi*N_MF+gj] = r_fou[gi] & r_fou[N_MF+gj];
      end
   end

   // LIMPA searches from index 0 inclusive; EMITE searches past the held index.
   assign w_incl   = (r_state == LIMPA);
   assign w_inicio = w_incl ? '0 : r_seq;
   assign w_ultimo = (r_cnt == c_LAT);

   prox_regra_ativa #(
      .N_R         (c_N_R)
   ) u_prox (
      .mascara     (w_mascara),
      .inicio      (w_inicio),
      .incl_inicio (w_incl),
      .prox        (w_prox),
      .achou       (w_achou)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= OCIOSO;
         r_fou       <= '0;
         r_cnt       <= '0;
         r_seq       <= '0;
         r_valida    <= 1'b0;
         r_reset_inf <= 1'b0;
         r_en_inf    <= 1'b0;
         r_fim       <= 1'b0;
         r_ocupado   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt;
         r_seq       <= w_seq;
         r_valida    <= w_valida;
         r_reset_inf <= w_reset_inf;
         r_en_inf    <= w_en_inf;
         r_fim       <= w_fim;
         r_ocupado   <= (w_next != OCIOSO);
         if ((r_state == OCIOSO) && EN_REGRAS) begin
            r_fou <= FOU_ativo;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         OCIOSO:  if (EN_REGRAS) w_next = LIMPA;
         LIMPA:   w_next = w_achou ? EMITE : FIM;
         EMITE:   if (w_ultimo) w_next = w_achou ? EMITE : FIM;
         FIM:     w_next = OCIOSO;
         default: w_next = OCIOSO;
      endcase
   end

   // Values presented on the outputs after the coming edge.
   always_comb begin
      w_seq       = r_seq;
      w_cnt       = r_cnt;
      w_valida    = 1'b0;
      w_en_inf    = 1'b0;
      w_reset_inf = (w_next == LIMPA);
      w_fim       = (w_next == FIM);
      if (w_next == EMITE) begin
         w_valida = 1'b1;
         if ((r_state == EMITE) && !w_ultimo) begin
            w_cnt = r_cnt + c_UM;
         end else begin
            w_cnt = c_UM;
            w_seq = w_prox;
         end
         w_en_inf = (w_cnt == c_LAT);
      end
   end

   assign Sequencia_regras = r_seq;
   assign regra_valida     = r_valida;
   assign Reset_Inf        = r_reset_inf;
   assign en_inf           = r_en_inf;
   assign fim              = r_fim;
   assign ocupado          = r_ocupado;
   assign estado           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_regras_fou.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_escalonador_regras_fou                                                |
// | Cycle-by-cycle scoreboard bench for the rule scheduler.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_escalonador_regras_fou;

   localparam int c_LAT = 2;

   // {estado, ocupado, Reset_Inf, regra_valida, en_inf, fim, Sequencia_regras}
   typedef logic [11:0] snap_t;

   logic       clk;
   logic       rst;
   logic       EN_REGRAS;
   logic [5:0] FOU_ativo;
   logic [3:0] Sequencia_regras;
   logic       regra_valida, Reset_Inf, en_inf, fim, ocupado;
   logic [2:0] estado;

   snap_t      sb[$];
   logic [3:0] m_seq;
   int         n_checks;
   int         n_err;

   escalonador_regras_fou #(
      .N_MF             (3),
      .LAT_INF          (c_LAT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .EN_REGRAS        (EN_REGRAS),
      .FOU_ativo        (FOU_ativo),
      .Sequencia_regras (Sequencia_regras),
      .regra_valida     (regra_valida),
      .Reset_Inf        (Reset_Inf),
      .en_inf           (en_inf),
      .fim              (fim),
      .ocupado          (ocupado),
      .estado           (estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t mk(input logic [2:0] st, input logic oc, input logic ri,
                                input logic rv, input logic en, input logic fm,
                                input logic [3:0] sq);
      return {st, oc, ri, rv, en, fm, sq};
   endfunction

   // Reference model: expected snapshots from LIMPA through the following OCIOSO cycle.
   function automatic void push_run(input logic [5:0] fou);
      sb.push_back(mk(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_seq));
      for (int r = 0; r < 9; r++) begin
         if (fou[r/3] && fou[3 + (r%3)]) begin
            for (int h = 1; h <= c_LAT; h++) begin
               sb.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, (h == c_LAT), 1'b0, 4'(r)));
            end
            m_seq = 4'(r);
         end
      end
      sb.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, m_seq));
      sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_seq));
   endfunction

   function automatic void push_idle(input int n);
      for (int k = 0; k < n; k++) begin
         sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_seq));
      end
   endfunction

   task automatic check(input string tag, input int c, input snap_t exp);
      snap_t obs;
      obs = {estado, ocupado, Reset_Inf, regra_valida, en_inf, fim, Sequencia_regras};
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s c=%0d observado=%h esperado=%h", tag, c, obs, exp);
      end
   endtask

   // Pops one snapshot per cycle; optional mid-run EN drop, disturbance and reset.
   task automatic consume(input string tag, input int en_drop, input int disturb,
                          input int abort);
      int c;
      c = 1;
      while (sb.size() > 0) begin
         check(tag, c, sb.pop_front());
         if (c == en_drop) EN_REGRAS = 1'b0;
         if (disturb > 0 && c == disturb) begin
            FOU_ativo = 6'b111_111;
            EN_REGRAS = 1'b1;
         end
         if (disturb > 0 && c == disturb + 1) EN_REGRAS = 1'b0;
         if (c == abort) begin
            rst = 1'b0;
            #1;
            check({tag, "_rst"}, c, '0);
            sb.delete();
            m_seq = '0;
            @(posedge clk);
            #1;
            rst = 1'b1;
         end
         c++;
         @(negedge clk);
      end
   endtask

   task automatic start(input logic [5:0] fou);
      @(negedge clk);
      FOU_ativo = fou;
      EN_REGRAS = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      m_seq     = '0;
      rst       = 1'b0;
      EN_REGRAS = 1'b0;
      FOU_ativo = '0;
      #12;
      check("reset", 0, '0);
      @(negedge clk);
      rst = 1'b1;
      push_idle(2);
      @(negedge clk);
      consume("idle", 0, 0, 0);

      push_run(6'b011_110);
      start(6'b011_110);
      consume("parcial", 1, 0, 0);

      push_run(6'b111_111);
      start(6'b111_111);
      consume("cheia", 1, 0, 0);

      push_run(6'b000_101);
      start(6'b000_101);
      consume("vazia", 1, 0, 0);

      // Mask change and EN pulse during EMITE must not affect the run.
      push_run(6'b001_001);
      push_idle(3);
      start(6'b001_001);
      consume("trava", 1, 2, 0);

      // Reset on the first beat of the third rule of a full run.
      push_run(6'b111_111);
      start(6'b111_111);
      consume("aborta", 1, 0, 6);
      push_idle(3);
      consume("pos_rst", 0, 0, 0);

      push_run(6'b111_111);
      start(6'b111_111);
      consume("reinicio", 1, 0, 0);

      // EN held high: three back-to-back runs, EN dropped on the third FIM.
      push_run(6'b010_010);
      push_run(6'b010_010);
      push_run(6'b010_010);
      push_idle(2);
      start(6'b010_010);
      consume("continuo", 14, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
